// File: rtl/cla16_pkg.sv
// Shared constants and types for the 16-bit two-level carry-lookahead adder.
package cla16_pkg;
  localparam int CLA_WIDTH   = 16;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = 4;

  typedef logic [CLA_WIDTH-1:0] operand_t;
endpackage

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead slice: local sums plus group generate/propagate
// for the second-level lookahead unit.
module cla4_block
  import cla16_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 gg,
  output logic                 gp
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Internal carries are flat sum-of-products, no ripple between bits.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cla16_adder.sv
// Registered 16-bit carry-lookahead adder, {Co,S} = X + Y + Cin, 1-cycle latency.
// Optional two's-complement overflow output Ovf when CLA16_ADDER_OVF_EN is defined.
module cla16_adder
  import cla16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Co
`ifdef CLA16_ADDER_OVF_EN
  ,
  output logic        Ovf
`endif
);

  operand_t               sum_d;
  operand_t               s_q;
  logic                   co_d;
  logic                   co_q;
  logic [CLA_NGROUPS-1:0] grp_g;
  logic [CLA_NGROUPS-1:0] grp_p;
  logic [CLA_NGROUPS:0]   grp_c;

  // Second-level lookahead: every group carry comes straight from GG/GP/Cin.
  assign grp_c[0] = Cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & Cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & Cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & Cin);

  for (genvar gi = 0; gi < CLA_NGROUPS; gi++) begin : g_grp
    cla4_block u_cla4 (
      .a  (X[gi*CLA_GROUP +: CLA_GROUP]),
      .b  (Y[gi*CLA_GROUP +: CLA_GROUP]),
      .ci (grp_c[gi]),
      .s  (sum_d[gi*CLA_GROUP +: CLA_GROUP]),
      .gg (grp_g[gi]),
      .gp (grp_p[gi])
    );
  end

  assign co_d = grp_c[CLA_NGROUPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= sum_d;
      co_q <= co_d;
    end
  end

  assign S  = s_q;
  assign Co = co_q;

`ifdef CLA16_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (X[15] == Y[15]) & (sum_d[15] != X[15]);

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla16_adder.sv
// Directed and back-to-back random checks of cla16_adder against hand-computed sums.
module tb_cla16_adder;

  logic        clk;
  logic        rst;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Cin;
  logic [15:0] S;
  logic        Co;
`ifdef CLA16_ADDER_OVF_EN
  logic        Ovf;
`endif

  int errors = 0;
  int checks = 0;

  cla16_adder dut (
    .clk (clk),
    .rst (rst),
    .X   (X),
    .Y   (Y),
    .Cin (Cin),
    .S   (S),
    .Co  (Co)
`ifdef CLA16_ADDER_OVF_EN
    ,
    .Ovf (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [15:0] es,
                           input logic eco, input logic eov);
    checks++;
    assert (S === es) else begin
      errors++;
      $error("FAIL %s S: got %h want %h", tag, S, es);
    end
    checks++;
    assert (Co === eco) else begin
      errors++;
      $error("FAIL %s Co: got %b want %b", tag, Co, eco);
    end
`ifdef CLA16_ADDER_OVF_EN
    checks++;
    assert (Ovf === eov) else begin
      errors++;
      $error("FAIL %s Ovf: got %b want %b", tag, Ovf, eov);
    end
`else
    if (eov) begin end
`endif
  endtask

  // Present operands before an edge, check the registered result just after it.
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic [15:0] es, input logic eco,
                      input logic eov);
    @(negedge clk);
    X = x; Y = y; Cin = c;
    @(posedge clk);
    #1;
    check_out(tag, es, eco, eov);
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] rx;
    logic [15:0] ry;
    logic        rc;
    logic        rov;

    rst = 1'b1; X = 16'h1234; Y = 16'h1111; Cin = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset", 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    step("add_1_1",   16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    step("add_3_3",   16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0);
    step("add_B_B",   16'h000B, 16'h000B, 1'b0, 16'h0016, 1'b0, 1'b0);
    step("cin_B_B",   16'h000B, 16'h000B, 1'b1, 16'h0017, 1'b0, 1'b0);
    step("wrap",      16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    step("all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step("grp_bound", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    step("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    step("neg_ovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    step("mid_carry", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Outputs must not follow input changes between edges.
    #2;
    X = 16'hAAAA; Y = 16'h5555; Cin = 1'b1;
    #2;
    check_out("hold", 16'h1000, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, rx} + {1'b0, ry} + {16'b0, rc};
      rov = (rx[15] == ry[15]) && (full[15] != rx[15]);
      step($sformatf("rand%0d", i), rx, ry, rc, full[15:0], full[16], rov);
    end

    // Reset in the same cycle as live operands discards that result.
    @(negedge clk);
    X = 16'h8001; Y = 16'h8001; Cin = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    check_out("mid_reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("resume", 16'h8001, 16'h8001, 1'b1, 16'h0003, 1'b1, 1'b1);
    step("resume2", 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
